// File: rtl/seg7_scan_display.sv
// seg7_scan_display
// -----------------
// Drives a 6-digit multiplexed common-anode seven-segment display from the six
// BCD digits of the binary-to-decimal converter (dig_5 = volts digit).
// The digits are snapshotted into shadow registers on `load`. The display is
// only ever driven from these shadow copies. A free-running scan counter then
// time-multiplexes the digit enables.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset (async assert, sync release)
//   dig_5..dig_0 BCD digits from the converter (10..15 display as a dash)
//   load         snapshot strobe, normally tied to measurement-done
//   hold         run/stop hold request (only used with SEG7_HOLD_BLINK_EN)
//   seg[7:0]     segment drive, active low: seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a
//   an[5:0]      digit enables, active low one-hot; an[i] selects digit i
//
// Handshake: `load` is a plain strobe with no valid/ready pairing. It is
// sampled every rising edge, never stalls, and produces no acknowledge.
//
// Optional feature macro: SEG7_HOLD_BLINK_EN. When it is defined, all anodes
// blink off while `hold` is high. When it is undefined, `hold` is ignored and
// no blink logic exists.
module seg7_scan_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 2,
  parameter int DP_POS       = 5,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dig_5,
  input  logic [3:0] dig_4,
  input  logic [3:0] dig_3,
  input  logic [3:0] dig_2,
  input  logic [3:0] dig_1,
  input  logic [3:0] dig_0,
  input  logic       load,
  input  logic       hold,
  output logic [7:0] seg,
  output logic [5:0] an
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     idx, idx_nxt;
  logic [5:0][3:0] sh;
  logic           frame_wrap;
  logic [5:0]     zero_from;
  logic [3:0]     cur_dig;
  logic           lz_blank;
  logic [6:0]     pat;
  logic [7:0]     seg_nxt;
  logic [5:0]     an_nxt;

  // Scan sequencing. The output registers are loaded from the *next* counter
  // and index values, so that an/seg always line up with the current cnt/idx.
  always_comb begin
    cnt_nxt    = cnt + 1'b1;
    idx_nxt    = idx;
    frame_wrap = 1'b0;
    if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt_nxt = '0;
      if (idx == 3'd5) begin
        idx_nxt    = 3'd0;
        frame_wrap = 1'b1;
      end else begin
        idx_nxt = idx + 3'd1;
      end
    end
  end

`ifdef SEG7_HOLD_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_ph, blink_ph_nxt;

  // Frames are counted only while hold is requested. Dropping hold clears the
  // counter and phase at the next edge, so scanning resumes immediately.
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_ph_nxt  = blink_ph;
    if (!hold) begin
      blink_cnt_nxt = '0;
      blink_ph_nxt  = 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_nxt = '0;
        blink_ph_nxt  = ~blink_ph;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_ph  <= blink_ph_nxt;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = hold;
`endif

  // Segment decode for the digit that will be showing after this edge.
  // zero_from[i] is set when shadow digit i and every digit above it are 0.
  // Dash codes are non-zero, so a dash is never blanked.
  always_comb begin
    zero_from[5] = (sh[5] == 4'd0);
    for (int i = 4; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (sh[i] == 4'd0);
    end

    cur_dig  = 4'd0;
    lz_blank = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (idx_nxt == 3'(i)) begin
        cur_dig  = sh[i];
        lz_blank = (i > DP_POS) && zero_from[i];
      end
    end

    case (cur_dig)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase

    seg_nxt[7]   = (idx_nxt != 3'(DP_POS));
    seg_nxt[6:0] = lz_blank ? 7'h7F : pat;

    // All anodes are off for the first BLANK_CYC cycles of each slot. This
    // hides segment transitions (ghosting) between neighbouring digits.
    if (cnt_nxt < CW'(BLANK_CYC)) begin
      an_nxt = 6'h3F;
    end else begin
      an_nxt = ~(6'b000001 << idx_nxt);
    end
`ifdef SEG7_HOLD_BLINK_EN
    if (hold && blink_ph_nxt) begin
      an_nxt = 6'h3F;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 3'd0;
      sh  <= '0;
      seg <= 8'hFF;
      an  <= 6'h3F;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      seg <= seg_nxt;
      an  <= an_nxt;
      if (load) begin
        sh <= {dig_5, dig_4, dig_3, dig_2, dig_1, dig_0};
      end
    end
  end

endmodule
